// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard controller: register index width,
// MULT/DIV tracker state encoding and default MULT/DIV latency.
package hazard_unit_pkg;
  localparam int REG_W             = 5;
  localparam int MULDIV_CYCLES_DEF = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;
endpackage

// File: rtl/hazard_unit_muldiv_tracker.sv
// Tracks the multi-cycle MULT/DIV unit: busy window after issue and a
// one-cycle done pulse once the result lands in HI/LO.
module muldiv_tracker
  import hazard_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int CNT_W         = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = MD_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Registered state may still show BUSY/done during the first reset cycle;
  // mask so the pipeline sees a clean idle unit for the whole reset window.
  assign busy_o = (state_q == MD_BUSY) && !reset_i;
  assign done_o = done_q && !reset_i;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller beside ID: load-use and MULT/DIV stalls,
// taken-branch fetch kill, and stage-register control during reset.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exWriteReg,
  input  logic             idBranchTaken,
  input  logic             idMulDivStart,
  input  logic             idReadsHiLo,
  output logic             pcStall,
  output logic             ifidStall,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             mdBusy,
  output logic             mdDone
);

  logic loadUse, mdHazard, stall;

  assign loadUse = exMemRead && (exWriteReg != '0) &&
                   ((exWriteReg == idRs) || (idUsesRt && (exWriteReg == idRt)));

  // A MULT/DIV blocked by a load-use must not issue; it retries next cycle.
  muldiv_tracker #(
    .MULDIV_CYCLES(MULDIV_CYCLES),
    .CNT_W        (CNT_W)
  ) u_md (
    .clk_i  (clk),
    .reset_i(reset),
    .start_i(idMulDivStart && !loadUse),
    .busy_o (mdBusy),
    .done_o (mdDone)
  );

  assign mdHazard = mdBusy && (idReadsHiLo || idMulDivStart);
  assign stall    = loadUse || mdHazard;

  always_comb begin
    pcStall   = 1'b0;
    ifidStall = 1'b0;
    ifidFlush = 1'b0;
    idexFlush = 1'b0;
    if (reset) begin
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (stall) begin
      pcStall   = 1'b1;
      ifidStall = 1'b1;
      idexFlush = 1'b1;
    end else if (idBranchTaken) begin
      ifidFlush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (MULT/DIV latency 4 and 1) share
// inputs and are checked against a cycle-timeline reference model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] idRs, idRt, exWriteReg;
  logic       idUsesRt, exMemRead, idBranchTaken, idMulDivStart, idReadsHiLo;

  logic pcS_a, ifS_a, ifF_a, idF_a, bsy_a, dn_a;
  logic pcS_b, ifS_b, ifF_b, idF_b, bsy_b, dn_b;

  hazard_unit #(.MULDIV_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exWriteReg(exWriteReg), .idBranchTaken(idBranchTaken),
    .idMulDivStart(idMulDivStart), .idReadsHiLo(idReadsHiLo),
    .pcStall(pcS_a), .ifidStall(ifS_a), .ifidFlush(ifF_a), .idexFlush(idF_a),
    .mdBusy(bsy_a), .mdDone(dn_a));

  hazard_unit #(.MULDIV_CYCLES(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exWriteReg(exWriteReg), .idBranchTaken(idBranchTaken),
    .idMulDivStart(idMulDivStart), .idReadsHiLo(idReadsHiLo),
    .pcStall(pcS_b), .ifidStall(ifS_b), .ifidFlush(ifF_b), .idexFlush(idF_b),
    .mdBusy(bsy_b), .mdDone(dn_b));

  always #5 clk = ~clk;

  wire [5:0] o_a = {pcS_a, ifS_a, ifF_a, idF_a, bsy_a, dn_a};
  wire [5:0] o_b = {pcS_b, ifS_b, ifF_b, idF_b, bsy_b, dn_b};

  int n_vec = 0;
  int n_err = 0;

  // Model: cycle index plus the cycle each unit last accepted a MULT/DIV.
  // Accepted in cycle k => busy in cycles k+1..k+C, done in cycle k+C+1.
  int cyc = 0;
  int lat   [2] = '{4, 1};
  bit have  [2] = '{0, 0};
  int iss_k [2] = '{0, 0};

  function automatic bit m_busy(int i);
    return have[i] && (cyc - iss_k[i] >= 1) && (cyc - iss_k[i] <= lat[i]);
  endfunction

  function automatic bit m_done(int i);
    return have[i] && (cyc - iss_k[i] == lat[i] + 1);
  endfunction

  function automatic bit m_lu();
    return exMemRead && exWriteReg != 0 &&
           (exWriteReg == idRs || (idUsesRt && exWriteReg == idRt));
  endfunction

  function automatic logic [5:0] m_out(int i);
    bit st;
    if (reset) return 6'b001100;
    st = m_lu() || (m_busy(i) && (idReadsHiLo || idMulDivStart));
    return {st, st, !st && idBranchTaken, st, m_busy(i), m_done(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) have[i] = 0;
      else if (idMulDivStart && !m_lu() && !m_busy(i)) begin
        have[i]  = 1;
        iss_k[i] = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clr();
    reset = 0; idRs = 0; idRt = 0; exWriteReg = 0; idUsesRt = 0; exMemRead = 0;
    idBranchTaken = 0; idMulDivStart = 0; idReadsHiLo = 0;
  endtask

  task automatic test_reset();
    clr(); reset = 1; idMulDivStart = 1; idBranchTaken = 1;
    for (int c = 0; c < 3; c++) begin
      #3; n_vec += 2;
      if (o_a !== 6'b001100) begin n_err++; $display("FAIL reset dut_a got %b want 001100", o_a); end
      if (o_b !== 6'b001100) begin n_err++; $display("FAIL reset dut_b got %b want 001100", o_b); end
      tick();
    end
    clr();
    #3; n_vec += 2;
    if (o_a !== m_out(0)) begin n_err++; $display("FAIL post_reset dut_a got %b want %b", o_a, m_out(0)); end
    if (o_b !== m_out(1)) begin n_err++; $display("FAIL post_reset dut_b got %b want %b", o_b, m_out(1)); end
    tick();
  endtask

  task automatic test_load_use();
    clr(); exMemRead = 1; exWriteReg = 8; idRs = 8;
    #3; n_vec += 2;
    if (o_a !== 6'b110100) begin n_err++; $display("FAIL load_use dut_a got %b want 110100", o_a); end
    if (o_b !== 6'b110100) begin n_err++; $display("FAIL load_use dut_b got %b want 110100", o_b); end
    tick();
    exWriteReg = 0; idRs = 0;
    #3; n_vec += 2;
    if (o_a !== 6'b000000) begin n_err++; $display("FAIL load_use_r0 dut_a got %b want 000000", o_a); end
    if (o_b !== 6'b000000) begin n_err++; $display("FAIL load_use_r0 dut_b got %b want 000000", o_b); end
    tick();
  endtask

  task automatic test_rt_gating();
    for (int u = 0; u < 2; u++) begin
      clr(); exMemRead = 1; exWriteReg = 9; idRt = 9; idRs = 3; idUsesRt = u[0];
      #3; n_vec += 2;
      if (o_a !== (u ? 6'b110100 : 6'b000000)) begin n_err++; $display("FAIL rt_gate u=%0d dut_a got %b", u, o_a); end
      if (o_b !== m_out(1)) begin n_err++; $display("FAIL rt_gate u=%0d dut_b got %b want %b", u, o_b, m_out(1)); end
      tick();
    end
  endtask

  task automatic test_branch();
    clr(); idBranchTaken = 1;
    #3; n_vec += 2;
    if (o_a !== 6'b001000) begin n_err++; $display("FAIL branch dut_a got %b want 001000", o_a); end
    if (o_b !== 6'b001000) begin n_err++; $display("FAIL branch dut_b got %b want 001000", o_b); end
    tick();
    exMemRead = 1; exWriteReg = 4; idRs = 4;
    #3; n_vec += 2;
    if (o_a !== 6'b110100) begin n_err++; $display("FAIL branch_lu dut_a got %b want 110100", o_a); end
    if (o_b !== 6'b110100) begin n_err++; $display("FAIL branch_lu dut_b got %b want 110100", o_b); end
    tick();
  endtask

  // One MULT issue, then an MFHI held in ID until the unit frees up.
  task automatic test_muldiv();
    clr(); idMulDivStart = 1;
    for (int c = 0; c < 8; c++) begin
      #3; n_vec += 2;
      if (o_a !== m_out(0)) begin n_err++; $display("FAIL muldiv c=%0d dut_a got %b want %b", c, o_a, m_out(0)); end
      if (o_b !== m_out(1)) begin n_err++; $display("FAIL muldiv c=%0d dut_b got %b want %b", c, o_b, m_out(1)); end
      tick();
      idMulDivStart = 0; idReadsHiLo = (c < 4);
    end
  endtask

  task automatic test_back_to_back();
    clr(); idMulDivStart = 1;
    for (int c = 0; c < 5; c++) begin
      #3; n_vec += 2;
      if (o_b !== m_out(1)) begin n_err++; $display("FAIL b2b c=%0d dut_b got %b want %b", c, o_b, m_out(1)); end
      if (o_a !== m_out(0)) begin n_err++; $display("FAIL b2b c=%0d dut_a got %b want %b", c, o_a, m_out(0)); end
      tick();
      if (c == 2) idMulDivStart = 0;
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid_busy();
    clr(); idMulDivStart = 1;
    tick(); idMulDivStart = 0;
    tick();
    tick(); reset = 1;
    for (int c = 0; c < 8; c++) begin
      #3; n_vec += 2;
      if (o_a !== m_out(0)) begin n_err++; $display("FAIL rst_busy c=%0d dut_a got %b want %b", c, o_a, m_out(0)); end
      if (o_b !== m_out(1)) begin n_err++; $display("FAIL rst_busy c=%0d dut_b got %b want %b", c, o_b, m_out(1)); end
      tick();
      if (c == 1) reset = 0;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset         = ($urandom_range(0, 49) == 0);
      idRs          = 5'($urandom_range(0, 3));
      idRt          = 5'($urandom_range(0, 3));
      exWriteReg    = 5'($urandom_range(0, 3));
      idUsesRt      = 1'($urandom);
      exMemRead     = ($urandom_range(0, 2) == 0);
      idBranchTaken = ($urandom_range(0, 3) == 0);
      idMulDivStart = ($urandom_range(0, 5) == 0);
      idReadsHiLo   = ($urandom_range(0, 4) == 0);
      #3; n_vec += 2;
      if (o_a !== m_out(0)) begin n_err++; $display("FAIL random c=%0d dut_a got %b want %b", c, o_a, m_out(0)); end
      if (o_b !== m_out(1)) begin n_err++; $display("FAIL random c=%0d dut_b got %b want %b", c, o_b, m_out(1)); end
      tick();
    end
  endtask

  initial begin
    clr(); reset = 1;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
